// File: rtl/r2_column_gen.sv
// r2_column_gen: turns a raster pixel stream into 5-tall column slices for a 5x5 window.
// Ports: clk, rst (async active-low); clear_i frame restart; valid_i/data_i pixel in;
//        S1..S5 column slice (oldest..current row); valid_o full column; last_o final
//        column of frame; col_o/row_o position of the slice.
module r2_column_gen #(
  parameter int COLS = 7,
  parameter int ROWS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic [7:0] S1,
  output logic [7:0] S2,
  output logic [7:0] S3,
  output logic [7:0] S4,
  output logic [7:0] S5,
  output logic       valid_o,
  output logic       last_o,
  output logic [9:0] col_o,
  output logic [9:0] row_o
);
  localparam int AW = $clog2(COLS);
  logic [7:0] lb0 [COLS];
  logic [7:0] lb1 [COLS];
  logic [7:0] lb2 [COLS];
  logic [7:0] lb3 [COLS];
  logic [9:0] col, row;
  logic [AW-1:0] ci;
  logic acc, col_end, row_end;
  assign acc = valid_i & ~clear_i;
  assign ci = col[AW-1:0];
  assign col_end = col == 10'(COLS - 1);
  assign row_end = row == 10'(ROWS - 1);
  // Line buffers are deliberately not reset; rows 0..3 refill them before any valid slice.
  always_ff @(posedge clk)
    if (acc) begin
      lb3[ci] <= lb2[ci];
      lb2[ci] <= lb1[ci];
      lb1[ci] <= lb0[ci];
      lb0[ci] <= data_i;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {S1, S2, S3, S4, S5} <= '0;
      {valid_o, last_o} <= '0;
      {col_o, row_o, col, row} <= '0;
    end else if (clear_i) begin
      {col, row} <= '0;
      {valid_o, last_o} <= '0;
    end else if (valid_i) begin
      S5 <= data_i;
      S4 <= lb0[ci];
      S3 <= lb1[ci];
      S2 <= lb2[ci];
      S1 <= lb3[ci];
      col_o <= col;
      row_o <= row;
      valid_o <= row >= 10'd4;
      last_o <= row_end & col_end;
      col <= col_end ? '0 : col + 10'd1;
      row <= col_end ? (row_end ? '0 : row + 10'd1) : row;
    end else begin
      {valid_o, last_o} <= '0;
    end
endmodule

// File: tb/tb_r2_column_gen.sv
// tb_r2_column_gen: directed self-checking bench for r2_column_gen (7x7 and 2x5 instances).
module tb_r2_column_gen;
  logic clk = 0, rst = 0, clear_i = 0, valid_i = 0;
  logic [7:0] data_i = 0;
  logic [7:0] S1, S2, S3, S4, S5;
  logic valid_o, last_o;
  logic [9:0] col_o, row_o;
  logic m_clear = 0, m_valid_i = 0;
  logic [7:0] m_data = 0;
  logic [7:0] m1, m2, m3, m4, m5;
  logic m_valid_o, m_last;
  logic [9:0] m_col, m_row;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  r2_column_gen #(.COLS(7), .ROWS(7)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .valid_i(valid_i), .data_i(data_i),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
    .valid_o(valid_o), .last_o(last_o), .col_o(col_o), .row_o(row_o)
  );

  r2_column_gen #(.COLS(2), .ROWS(5)) dut_min (
    .clk(clk), .rst(rst), .clear_i(m_clear), .valid_i(m_valid_i), .data_i(m_data),
    .S1(m1), .S2(m2), .S3(m3), .S4(m4), .S5(m5),
    .valid_o(m_valid_o), .last_o(m_last), .col_o(m_col), .row_o(m_row)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams one 7x7 frame with pixel = base + 10*r + c, optionally with an idle cycle after each pixel.
  task automatic frame(input int base, input bit gap, output int pulses);
    pulses = 0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        valid_i = 1;
        data_i = 8'(base + 10 * r + c);
        step();
        checks++;
        if (valid_o !== (r >= 4)) begin
          errors++;
          $display("FAIL frame_valid r=%0d c=%0d: got %b want %b", r, c, valid_o, r >= 4);
        end
        if (valid_o) pulses++;
        if (r >= 4) begin
          checks++;
          if (S1 !== 8'(base + 10 * (r - 4) + c) || S2 !== 8'(base + 10 * (r - 3) + c) ||
              S3 !== 8'(base + 10 * (r - 2) + c) || S4 !== 8'(base + 10 * (r - 1) + c) ||
              S5 !== 8'(base + 10 * r + c) || row_o !== 10'(r) || col_o !== 10'(c) ||
              last_o !== (r == 6 && c == 6)) begin
            errors++;
            $display("FAIL frame_slice r=%0d c=%0d: got S=%0d,%0d,%0d,%0d,%0d row=%0d col=%0d last=%b want S=%0d..%0d last=%b",
                     r, c, S1, S2, S3, S4, S5, row_o, col_o, last_o,
                     base + 10 * (r - 4) + c, base + 10 * r + c, r == 6 && c == 6);
          end
        end
        if (gap) begin
          valid_i = 0;
          step();
          checks++;
          if (valid_o !== 1'b0 || last_o !== 1'b0 || S5 !== 8'(base + 10 * r + c) ||
              (r >= 4 && S1 !== 8'(base + 10 * (r - 4) + c))) begin
            errors++;
            $display("FAIL gap_hold r=%0d c=%0d: got valid=%b last=%b S1=%0d S5=%0d want valid=0 last=0 S5=%0d",
                     r, c, valid_o, last_o, S1, S5, base + 10 * r + c);
          end
        end
      end
  endtask

  task automatic test_reset();
    checks++;
    if ({S1, S2, S3, S4, S5, valid_o, last_o, col_o, row_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got S5=%0d valid=%b col=%0d row=%0d want all 0", S5, valid_o, col_o, row_o);
    end
  endtask

  task automatic test_single_frame();
    int p;
    frame(0, 0, p);
    valid_i = 0;
    checks++;
    if (p != 21) begin
      errors++;
      $display("FAIL single_pulses: got %0d want 21", p);
    end
    step();
    checks++;
    if (valid_o !== 1'b0 || last_o !== 1'b0 || S5 !== 8'd66) begin
      errors++;
      $display("FAIL single_idle: got valid=%b last=%b S5=%0d want 0 0 66", valid_o, last_o, S5);
    end
  endtask

  task automatic test_gapped();
    int p;
    frame(0, 1, p);
    checks++;
    if (p != 21) begin
      errors++;
      $display("FAIL gapped_pulses: got %0d want 21", p);
    end
  endtask

  task automatic test_back_to_back();
    int p1, p2;
    frame(0, 0, p1);
    frame(100, 0, p2);
    valid_i = 0;
    checks++;
    if (p1 != 21 || p2 != 21) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d,%0d want 21,21", p1, p2);
    end
  endtask

  task automatic test_clear();
    int p;
    for (int i = 0; i < 37; i++) begin
      valid_i = 1;
      data_i = 8'(10 * (i / 7) + i % 7);
      step();
    end
    clear_i = 1;
    data_i = 8'd52;
    step();
    clear_i = 0;
    valid_i = 0;
    checks++;
    if (valid_o !== 1'b0 || last_o !== 1'b0 || S5 !== 8'd51) begin
      errors++;
      $display("FAIL clear_drop: got valid=%b last=%b S5=%0d want 0 0 51", valid_o, last_o, S5);
    end
    frame(0, 0, p);
    valid_i = 0;
    checks++;
    if (p != 21) begin
      errors++;
      $display("FAIL clear_restart_pulses: got %0d want 21", p);
    end
  endtask

  task automatic test_async_reset();
    int p;
    for (int i = 0; i < 38; i++) begin
      valid_i = 1;
      data_i = 8'(10 * (i / 7) + i % 7);
      step();
    end
    valid_i = 0;
    checks++;
    if (valid_o !== 1'b1 || S5 !== 8'd52) begin
      errors++;
      $display("FAIL pre_reset: got valid=%b S5=%0d want 1 52", valid_o, S5);
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({S1, S2, S3, S4, S5, valid_o, last_o, col_o, row_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: got S5=%0d valid=%b col=%0d row=%0d want all 0", S5, valid_o, col_o, row_o);
    end
    #2 rst = 1;
    frame(0, 0, p);
    valid_i = 0;
    checks++;
    if (p != 21) begin
      errors++;
      $display("FAIL reset_frame_pulses: got %0d want 21", p);
    end
  endtask

  task automatic test_minimal();
    int p = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 2; c++) begin
        m_valid_i = 1;
        m_data = 8'(10 * r + c);
        step();
        checks++;
        if (m_valid_o !== (r == 4)) begin
          errors++;
          $display("FAIL min_valid r=%0d c=%0d: got %b want %b", r, c, m_valid_o, r == 4);
        end
        if (m_valid_o) begin
          p++;
          checks++;
          if (m1 !== 8'(c) || m2 !== 8'(10 + c) || m3 !== 8'(20 + c) || m4 !== 8'(30 + c) ||
              m5 !== 8'(40 + c) || m_row !== 10'd4 || m_col !== 10'(c) || m_last !== (c == 1)) begin
            errors++;
            $display("FAIL min_slice c=%0d: got S=%0d,%0d,%0d,%0d,%0d row=%0d col=%0d last=%b want S=%0d..%0d last=%b",
                     c, m1, m2, m3, m4, m5, m_row, m_col, m_last, c, 40 + c, c == 1);
          end
        end
      end
    m_valid_i = 0;
    checks++;
    if (p != 2) begin
      errors++;
      $display("FAIL min_pulses: got %0d want 2", p);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step();
    step();
    test_reset();
    @(negedge clk) rst = 1;
    step();
    test_single_frame();
    test_gapped();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_minimal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/r2_column_gen.md
Name: r2_column_gen

Overview:
- Front end of the radius-2 (5x5) window datapath. It turns a raster pixel stream into 5-tall column slices S1..S5, one slice per accepted pixel, which feed the 5x5 sliding-window sum stage.
- Four internal line buffers of COLS pixels each supply the four rows above the current one.
- Frame position is tracked so that only fully populated columns are flagged valid, and the last column of a frame is marked.

Parameters:
- COLS, 7, pixels per image row (line-buffer depth); must be >= 2.
- ROWS, 7, rows per frame; must be >= 5.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous frame restart: zeroes the row/col counters and drops any partial frame.
- valid_i  input  1  data_i carries a pixel this cycle.
- data_i  input  8  pixel in raster order (row-major, col 0 first).
- S1  output  8  pixel at (row-4, col); oldest row.
- S2  output  8  pixel at (row-3, col).
- S3  output  8  pixel at (row-2, col); centre row of the window.
- S4  output  8  pixel at (row-1, col).
- S5  output  8  pixel at (row, col); the current pixel.
- valid_o  output  1  S1..S5 form a complete column (row >= 4).
- last_o  output  1  with valid_o, marks the final column of the frame (row ROWS-1, col COLS-1).
- col_o  output  10  column index of the current output slice.
- row_o  output  10  row index of the current output slice.

Behaviour:
- Reset (rst=0, asynchronous): S1..S5, valid_o, last_o, col_o, row_o, and the internal col/row counters all go to 0. Line-buffer contents are not reset.
- Counters:
  - col increments on each accepted pixel and wraps COLS-1 -> 0.
  - When col wraps, row increments.
  - row wraps ROWS-1 -> 0 on the last pixel of the frame.
  - The next frame then starts with no gap cycle.
- Accepted pixel: valid_i=1 and clear_i=0. For pixel p at (r,c), the next clock edge registers:
  - S5 <= p
  - S4 <= LB0[c]
  - S3 <= LB1[c]
  - S2 <= LB2[c]
  - S1 <= LB3[c]
  - col_o <= c, row_o <= r
  - valid_o <= (r >= 4)
  - last_o <= (r == ROWS-1 && c == COLS-1)
  - In the same edge the buffers shift: LB3[c] <= LB2[c], LB2[c] <= LB1[c], LB1[c] <= LB0[c], LB0[c] <= p.
- Latency: exactly 1 cycle from an accepted pixel to its slice on the outputs.
- valid_o and last_o are single-cycle: they drop to 0 on any cycle with no accepted pixel.
- Idle cycle (valid_i=0): S1..S5, col_o and row_o hold their values. Buffers and counters do not change.
- Buffer addressing: a write and a read to the same LB entry c in one cycle return the old content (read-before-write).
- Valid slices per frame: exactly (ROWS-4)*COLS.
- Rows 0..3 of each frame never assert valid_o. This means stale data from the previous frame is never flagged valid, since rows 0..3 overwrite all four buffers before row 4.
- clear_i=1:
  - Counters go to 0 on the next edge; valid_o and last_o go to 0.
  - A pixel presented in the same cycle is discarded; clear_i has priority over valid_i.
  - Buffer contents are left as they are.
- Reset mid-frame: counters and outputs return to 0 immediately. The first pixel after reset is treated as (0,0).
- Widths: counters are 10-bit, supporting COLS and ROWS up to 1023.

Test Plan:
- Single frame, COLS=7, ROWS=7, pixel value = 10*r + c, valid_i held high for 49 cycles:
  - valid_o is first asserted 1 cycle after the 29th pixel (r=4, c=0), with S1..S5 = 0, 10, 20, 30, 40.
  - Exactly 21 valid_o pulses in total.
  - The final pulse has S1..S5 = 26, 36, 46, 56, 66, last_o=1, row_o=6, col_o=6.
- Gapped input: same frame with valid_i toggling 1,0,1,0:
  - Identical sequence of 21 slices.
  - S outputs hold during gaps; valid_o is low in every gap cycle.
- Back-to-back frames: frame 2 pixels = 100 + 10*r + c, sent immediately after frame 1:
  - No valid_o during frame-2 rows 0..3.
  - First frame-2 slice is S1..S5 = 100, 110, 120, 130, 140, with no frame-1 data.
- clear_i mid-frame: assert clear_i together with the pixel at (5,2), then restart at (0,0):
  - That pixel is dropped; valid_o=0 in the following cycle.
  - The next valid slice appears only after 28 new pixels.
- Asynchronous reset: pull rst low mid-cycle during row 5:
  - All outputs go to 0 without waiting for a clock edge.
  - After release, a full frame produces exactly 21 valid slices.
- Minimal frame, COLS=2, ROWS=5:
  - Exactly 2 valid slices, both on row 4.
  - last_o is asserted on the second slice.
